// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand-issue and result-capture stage around a combinational ALU.
// Stage 1 registers the forwarded operands and selector that drive the ALU.
// Stage 2 captures the ALU result for writeback.
// Valid/ready handshakes on both sides let decode and writeback stall independently.
module alu_issue_stage #(
  parameter int WIDTH   = 32,
  parameter int SEL_W   = 3,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [RADDR_W-1:0] in_rs,
  input  logic [RADDR_W-1:0] in_rt,
  input  logic [RADDR_W-1:0] in_dest,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [WIDTH-1:0]   alu_i1,
  output logic [WIDTH-1:0]   alu_i2,
  output logic [SEL_W-1:0]   alu_sel,
  input  logic [WIDTH-1:0]   alu_o,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [RADDR_W-1:0] out_dest
);

  logic               s1_valid;
  logic               s2_valid;
  logic [RADDR_W-1:0] s1_dest;
  logic               s2_take;
  logic               s1_adv;
  logic               in_fire;
  logic [WIDTH-1:0]   fwd_a;
  logic [WIDTH-1:0]   fwd_b;

  // Handshake chain: ready passes straight through from writeback to decode.
  always_comb begin
    s2_take  = !s2_valid || out_ready;
    s1_adv   = s1_valid && s2_take;
    in_ready = !s1_valid || s1_adv;
    in_fire  = in_valid && in_ready;
  end

  // Operand bypass: the youngest in-flight producer wins, and tag 0 never forwards.
  always_comb begin
    fwd_a = in_a;
    fwd_b = in_b;
    if (s1_valid && (s1_dest != '0) && (in_rs == s1_dest)) begin
      fwd_a = alu_o;
    end else if (s2_valid && (out_dest != '0) && (in_rs == out_dest)) begin
      fwd_a = out_data;
    end
    if (s1_valid && (s1_dest != '0) && (in_rt == s1_dest)) begin
      fwd_b = alu_o;
    end else if (s2_valid && (out_dest != '0) && (in_rt == out_dest)) begin
      fwd_b = out_data;
    end
  end

  // Pipeline registers: stage 2 captures the ALU result, stage 1 loads issued operands.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      alu_i1   <= '0;
      alu_i2   <= '0;
      alu_sel  <= '0;
      s1_dest  <= '0;
      out_data <= '0;
      out_dest <= '0;
    end else begin
      if (s1_adv) begin
        out_data <= alu_o;
        out_dest <= s1_dest;
        s2_valid <= 1'b1;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end

      if (in_fire) begin
        alu_i1   <= fwd_a;
        alu_i2   <= fwd_b;
        alu_sel  <= in_sel;
        s1_dest  <= in_dest;
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: self-checking bench for alu_issue_stage.
// A stand-in ALU drives alu_o; a list of in-flight ops serves as the reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_dest;
  logic [2:0]  in_sel;
  logic [31:0] alu_i1;
  logic [31:0] alu_i2;
  logic [2:0]  alu_sel;
  logic [31:0] alu_o;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_dest;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic [4:0]  dest;
    logic [31:0] res;
  } op_t;

  op_t         pipeQ[$];
  bit          newest;
  bit          modelKnown;
  bit          afterReset;
  int          checkCount;
  int          passCount;
  logic        lastValid;
  logic [31:0] lastData;
  logic [4:0]  lastDest;

  alu_issue_stage #(.WIDTH(32), .SEL_W(3), .RADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_rs(in_rs), .in_rt(in_rt),
    .in_dest(in_dest), .in_sel(in_sel),
    .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_sel(alu_sel), .alu_o(alu_o),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_dest(out_dest)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural ALU; selector 0 is plain addition.
  function automatic logic [31:0] aluFn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] sel);
    case (sel)
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  assign alu_o = aluFn(alu_i1, alu_i2, alu_sel);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    else
      passCount++;
  endtask

  // Operand value as seen by a new op: youngest in-flight producer with a matching nonzero tag.
  function automatic logic [31:0] resolve(input logic [4:0] tag, input logic [31:0] rf);
    for (int i = pipeQ.size() - 1; i >= 0; i--)
      if (tag != 5'd0 && pipeQ[i].dest == tag) return pipeQ[i].res;
    return rf;
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] dst, input logic [2:0] sel,
                               input logic ordy, input logic fl, input logic rn);
    bit  expReady;
    bit  expValid;
    bit  s1Busy;
    op_t op;
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_rs = rs; in_rt = rt;
    in_dest = dst; in_sel = sel; out_ready = ordy; flush = fl; reset_n = rn;
    #1;
    lastValid = out_valid; lastData = out_data; lastDest = out_dest;
    expReady = (pipeQ.size() < 2) || ordy;
    expValid = (pipeQ.size() == 2) || (pipeQ.size() == 1 && !newest);
    s1Busy   = (pipeQ.size() == 2) || (pipeQ.size() == 1 && newest);
    if (modelKnown) begin
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expReady});
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expValid});
      if (expValid) begin
        checkOutput("out_data", out_data, pipeQ[0].res);
        checkOutput("out_dest", {27'd0, out_dest}, {27'd0, pipeQ[0].dest});
      end
      if (s1Busy) begin
        checkOutput("alu_i1", alu_i1, pipeQ[pipeQ.size()-1].a);
        checkOutput("alu_i2", alu_i2, pipeQ[pipeQ.size()-1].b);
        checkOutput("alu_sel", {29'd0, alu_sel}, {29'd0, pipeQ[pipeQ.size()-1].sel});
      end
      if (afterReset) begin
        checkOutput("rst_alu_i1", alu_i1, 32'd0);
        checkOutput("rst_alu_i2", alu_i2, 32'd0);
        checkOutput("rst_alu_sel", {29'd0, alu_sel}, 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_out_dest", {27'd0, out_dest}, 32'd0);
        afterReset = 0;
      end
    end
    if (!rn) begin
      pipeQ.delete();
      newest = 0;
      afterReset = 1;
      modelKnown = 1;
    end else if (modelKnown) begin
      op.a    = resolve(rs, a);
      op.b    = resolve(rt, b);
      op.sel  = sel;
      op.dest = dst;
      op.res  = aluFn(op.a, op.b, sel);
      if (expValid && ordy) void'(pipeQ.pop_front());
      if (v && expReady) begin
        pipeQ.push_back(op);
        newest = 1;
      end else begin
        newest = 0;
      end
      if (fl) begin
        pipeQ.delete();
        newest = 0;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, ordy, 1'b0, 1'b1);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] dst, input logic ordy);
    applyStimulus(1'b1, a, b, rs, rt, dst, 3'd0, ordy, 1'b0, 1'b1);
  endtask

  initial begin
    checkCount = 0; passCount = 0; newest = 0; modelKnown = 0; afterReset = 0;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_rs = '0; in_rt = '0; in_dest = '0; in_sel = '0;

    // Reset held two cycles with a valid op offered.
    applyStimulus(1'b1, 32'd9, 32'd9, 5'd0, 5'd0, 5'd1, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd9, 32'd9, 5'd0, 5'd0, 5'd1, 3'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    checkOutput("idle_no_output", {31'd0, lastValid}, 32'd0);

    // Single op: result appears two edges after the fire.
    issue(32'd5, 32'd7, 5'd0, 5'd0, 5'd3, 1'b1);
    idle(1'b1);
    idle(1'b1);
    checkOutput("single_valid", {31'd0, lastValid}, 32'd1);
    checkOutput("single_data", lastData, 32'd12);
    checkOutput("single_dest", {27'd0, lastDest}, 32'd3);

    // Back-to-back forwarding from stage 1 and then stage 2.
    issue(32'd5, 32'd7, 5'd0, 5'd0, 5'd3, 1'b1);
    issue(32'd0, 32'd1, 5'd3, 5'd0, 5'd4, 1'b1);
    issue(32'd0, 32'd0, 5'd0, 5'd3, 5'd5, 1'b1);
    idle(1'b1);
    checkOutput("fwd_s1_data", lastData, 32'd13);
    idle(1'b1);
    checkOutput("fwd_s2_data", lastData, 32'd12);
    idle(1'b1);

    // Tag 0 never forwards.
    issue(32'd99, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    issue(32'd2, 32'd2, 5'd0, 5'd0, 5'd6, 1'b1);
    idle(1'b1);
    idle(1'b1);
    checkOutput("dest0_data", lastData, 32'd4);
    idle(1'b1);

    // Backpressure: five stalled cycles offering three ops, then drain.
    issue(32'd10, 32'd1, 5'd0, 5'd0, 5'd7, 1'b0);
    issue(32'd20, 32'd2, 5'd0, 5'd0, 5'd8, 1'b0);
    for (int i = 0; i < 3; i++) issue(32'd30, 32'd3, 5'd0, 5'd0, 5'd9, 1'b0);
    checkOutput("bp_stalled_data", lastData, 32'd11);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Flush with two ops in flight: neither is ever output.
    issue(32'd1, 32'd1, 5'd0, 5'd0, 5'd1, 1'b0);
    issue(32'd2, 32'd2, 5'd0, 5'd0, 5'd2, 1'b0);
    applyStimulus(1'b1, 32'd3, 32'd3, 5'd0, 5'd0, 5'd3, 3'd0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    checkOutput("flush_valid", {31'd0, lastValid}, 32'd0);
    idle(1'b1);

    // Reset mid-stream: same loss of in-flight ops, registers cleared.
    issue(32'd4, 32'd4, 5'd0, 5'd0, 5'd1, 1'b0);
    issue(32'd5, 32'd5, 5'd0, 5'd0, 5'd2, 1'b0);
    applyStimulus(1'b1, 32'd6, 32'd6, 5'd0, 5'd0, 5'd3, 3'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    checkOutput("reset_valid", {31'd0, lastValid}, 32'd0);
    idle(1'b1);

    // Randomized traffic with narrow tags to exercise forwarding.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), $urandom, $urandom,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 3'($urandom_range(0, 5)),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 59) != 0));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand-issue and result-capture stage wrapped around the combinational ALU.
- Registers operands and selector from decode, drives the ALU inputs, and captures the ALU output into a result register for writeback.
- Forwards in-flight results to newly issued operands.
- Uses a valid/ready handshake on both sides, so decode and writeback can stall independently.

Parameters:
- WIDTH, 32, operand/result width; matches ALU I1/I2/O.
- SEL_W, 3, ALU selector width; matches ALU Selector.
- RADDR_W, 5, register address width for source/destination tags.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- flush  input  1  discard all in-flight ops at next edge.
- in_valid  input  1  decode presents an op.
- in_ready  output  1  stage accepts the op this cycle.
- in_a  input  WIDTH  register-file value for operand A.
- in_b  input  WIDTH  register-file value for operand B.
- in_rs  input  RADDR_W  source register tag of A.
- in_rt  input  RADDR_W  source register tag of B.
- in_dest  input  RADDR_W  destination tag; 0 = no writeback/forward.
- in_sel  input  SEL_W  ALU selector, passed through opaquely.
- alu_i1  output  WIDTH  to ALU I1 (registered).
- alu_i2  output  WIDTH  to ALU I2 (registered).
- alu_sel  output  SEL_W  to ALU Selector (registered).
- alu_o  input  WIDTH  from ALU O (combinational from alu_i1/i2/sel).
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  writeback consumes the result.
- out_data  output  WIDTH  captured ALU result.
- out_dest  output  RADDR_W  destination tag of out_data.

Behaviour:
- Reset (reset_n=0 at edge): s1_valid=0, s2_valid=0, alu_i1=alu_i2=0, alu_sel=0, s1_dest=0, out_data=0, out_dest=0. in_ready=1 and out_valid=0 starting the cycle after reset. Reset wins over every other input, including mid-operation; in-flight ops are lost.
- Stage 1 (issue regs) holds alu_i1, alu_i2, alu_sel, s1_dest, s1_valid.
- Stage 2 (result regs) holds out_data, out_dest, s2_valid=out_valid.
- s2_take = !s2_valid | out_ready.
- s1_adv = s1_valid & s2_take.
- in_ready = !s1_valid | s1_adv. Combinational, independent of in_valid.
- in_fire = in_valid & in_ready.
- On s1_adv: out_data<=alu_o; out_dest<=s1_dest; s2_valid<=1.
- Else if out_ready: s2_valid<=0. When s2_valid=1 and out_ready=0, out_data/out_dest hold stable.
- On in_fire: load stage 1 with forwarded operands and set s1_valid=1.
- Else if s1_adv: s1_valid<=0. Otherwise stage 1 holds, including alu_* stable under stall.
- Forwarding, operand A (operand B identical using in_rt):
  - Use alu_o if s1_valid & s1_dest!=0 & in_rs==s1_dest.
  - Else use out_data if s2_valid & out_dest!=0 & in_rs==out_dest.
  - Else use in_a.
  - The youngest producer (stage 1) has priority.
- Tag 0 never forwards, even when valid.
- A consumed out_data (out_ready=1 same cycle) is still eligible for forwarding that cycle.
- Latency: in_fire at edge N; ALU inputs valid after N; out_valid=1 after edge N+1. Two-cycle latency, one op/cycle throughput with out_ready held high.
- Full pipe: both valid, out_ready=0 → in_ready=0. When out_ready rises, in_ready=1 in the same cycle (pass-through ready chain).
- Flush (reset_n=1, flush=1): s1_valid<=0 and s2_valid<=0. Any in_fire that cycle is discarded. The data registers need not clear. in_ready remains as computed (the op is accepted then dropped).
- Width: values pass through unmodified; no extension or truncation. Selector is never decoded here.

Test Plan:
- Reset/idle: hold reset_n=0 for 2 cycles with in_valid=1 → out_valid=0, alu_i1=0, in_ready=1 after release; no spurious output.
- Single op: behavioural ALU model O=I1+I2; in_a=5, in_b=7, in_dest=3, one fire → exactly 2 edges later out_valid=1, out_data=12, out_dest=3.
- Back-to-back forwarding:
  - op1 a=5,b=7,dest=3.
  - Next cycle op2 rs=3, in_a=0 (stale), b=1, dest=4 → op2 out_data=13 (from stage 1).
  - Op3 two cycles after op1 with rt=3, in_b=0 (stale), a=0 → out_data=12 (forwarded from stage 2).
- Dest-0 guard: op1 dest=0 producing 99; op2 rs=0, in_a=2, b=2 → out_data=4, no forward.
- Backpressure: out_ready=0 for 5 cycles with 3 ops offered → in_ready drops after 2 accepted. out_data/out_dest stable throughout. On out_ready=1, results drain in order with none dropped or duplicated.
- Flush/reset mid-op: 2 ops in flight, flush=1 one cycle → out_valid=0 next cycle and the ops are never output. Repeat with reset_n=0 mid-stream → same outcome, all regs 0.
